// File: rtl/legv8_instr_encoder_if.sv
// rtl/legv8_instr_encoder_if.sv - request handshake and instruction-memory write bus
interface legv8_instr_encoder_if #(
    parameter int ADDR_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [25:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_busy;

    // master: request source and memory sink; slave: the encoder
    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, imem_busy,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, imem_busy,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/legv8_instr_encoder.sv
// rtl/legv8_instr_encoder.sv - LEGv8 instruction encoder loading words into instruction memory
module legv8_instr_encoder #(
    parameter int ADDR_W    = 64,
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     num_instr,
    legv8_instr_encoder_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     written
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [CNT_W-1:0]  remaining;
    logic              complete;
    logic              hs;
    logic [32:0]       enc;

    // Bit 32 flags a valid op; bits 31:0 are the encoded word.
    function automatic logic [32:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                           input logic [4:0] rn, input logic [4:0] rm,
                                           input logic [25:0] imm);
        logic [32:0] r;
        r = '0;
        case (op)
            4'd0:    r = {1'b1, 11'b11111000010, imm[8:0], 2'b00, rn, rd};
            4'd1:    r = {1'b1, 11'b11111000000, imm[8:0], 2'b00, rn, rd};
            4'd2:    r = {1'b1, 8'b10110100, imm[18:0], rd};
            4'd3:    r = {1'b1, 11'b10001011000, rm, 6'd0, rn, rd};
            4'd4:    r = {1'b1, 11'b11001011000, rm, 6'd0, rn, rd};
            4'd5:    r = {1'b1, 11'b10001010000, rm, 6'd0, rn, rd};
            4'd6:    r = {1'b1, 11'b10101010000, rm, 6'd0, rn, rd};
            4'd7:    r = {1'b1, 11'b11010011011, 5'd0, imm[5:0], rn, rd};
            4'd8:    r = {1'b1, 11'b11010011010, 5'd0, imm[5:0], rn, rd};
            4'd9:    r = {1'b1, 6'b000101, imm};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign complete     = bus.imem_we && !bus.imem_busy;
    assign bus.in_ready = (state == LOAD) && (remaining != '0) && (!bus.imem_we || complete);
    assign hs           = bus.in_valid && bus.in_ready;
    assign enc          = encode(bus.in_op, bus.in_rd, bus.in_rn, bus.in_rm, bus.in_imm);
    // A word refilled in the same cycle the buffer drains lands one step past the draining one.
    assign ptr_next     = complete ? ptr + ADDR_W'(ADDR_STEP) : ptr;
    assign busy         = (state == LOAD) || (state == DRAIN);
    assign done         = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            remaining      <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            err            <= 1'b0;
            written        <= '0;
        end else begin
            if (complete) begin
                bus.imem_we <= 1'b0;
                ptr         <= ptr_next;
                written     <= written + CNT_W'(1);
            end
            if (hs) begin
                remaining <= remaining - CNT_W'(1);
                if (enc[32]) begin
                    bus.imem_we    <= 1'b1;
                    bus.imem_addr  <= ptr_next;
                    bus.imem_wdata <= enc[31:0];
                end else begin
                    err <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= base_addr;
                        remaining <= num_instr;
                        err       <= 1'b0;
                        written   <= '0;
                        state     <= (num_instr == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (remaining == '0 || (hs && remaining == CNT_W'(1)))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.imem_we || complete)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb/tb_legv8_instr_encoder.sv - self-checking bench for legv8_instr_encoder
module tb_legv8_instr_encoder;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] base_addr;
    logic [15:0] num_instr;
    logic        busy, done, err;
    logic [15:0] written;

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;
    logic        rand_busy = 1'b0;
    logic [63:0] exp_addr;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [25:0] imm;
        logic [31:0] word;
    } vec_t;
    vec_t vecs[14];

    legv8_instr_encoder_if #(.ADDR_W(64)) bus ();

    legv8_instr_encoder #(.ADDR_W(64), .ADDR_STEP(4), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_instr (num_instr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .written   (written)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.imem_we && !bus.imem_busy) begin
            exp_t e;
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h required=none", bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", bus.imem_addr, e.addr);
                chk("write_data", {32'd0, bus.imem_wdata}, {32'd0, e.data});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_busy) bus.imem_busy = 1'($urandom_range(0, 1));
    end

    task automatic session(input logic [63:0] base, input logic [15:0] num);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_instr = num;
        exp_addr = base;
        wr_seen = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm, input logic [31:0] word);
        bit ok = 0;
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_rd = rd; bus.in_rn = rn;
        bus.in_rm = rm; bus.in_imm = imm;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        if (ok) begin
            if (op <= 4'd9) begin
                exp_q.push_back('{exp_addr, word});
                exp_addr = exp_addr + 64'd4;
            end
            @(posedge clk); #1;
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout op=%0d in_ready=%b required=1", op, bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound, input logic [15:0] exp_written,
                             input logic exp_err);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({name, "_done"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({name, "_written"}, 64'(written), 64'(exp_written));
            chk({name, "_err"}, 64'(err), 64'(exp_err));
            chk({name, "_busy"}, 64'(busy), 64'd0);
            chk({name, "_wr_seen"}, 64'(wr_seen), 64'(exp_written));
            chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            chk({name, "_done_pulse"}, 64'(done), 64'd0);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_outs"},
            {35'd0, bus.in_ready, bus.imem_we, busy, done, err, 8'd0, written},
            64'd0);
        chk({name, "_addr"}, bus.imem_addr, 64'd0);
        chk({name, "_wdata"}, {32'd0, bus.imem_wdata}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{4'd3,  5'd3,  5'd1,  5'd2,  26'h0,       32'h8B020023};
        vecs[1]  = '{4'd5,  5'd7,  5'd8,  5'd9,  26'h0,       32'h8A090107};
        vecs[2]  = '{4'd6,  5'd31, 5'd30, 5'd29, 26'h0,       32'hAA1D03DF};
        vecs[3]  = '{4'd3,  5'd1,  5'd2,  5'd3,  26'h3F,      32'h8B030041};
        vecs[4]  = '{4'd7,  5'd2,  5'd3,  5'd7,  26'h4,       32'hD3601062};
        vecs[5]  = '{4'd8,  5'd4,  5'd5,  5'd0,  26'h7F,      32'hD340FCA4};
        vecs[6]  = '{4'd13, 5'd1,  5'd1,  5'd1,  26'h1,       32'h0};
        vecs[7]  = '{4'd1,  5'd9,  5'd10, 5'd0,  26'h1FF,     32'hF81FF149};
        vecs[8]  = '{4'd9,  5'd0,  5'd0,  5'd0,  26'h3FFFFFF, 32'h17FFFFFF};
        vecs[9]  = '{4'd2,  5'd0,  5'd0,  5'd0,  26'hFFFFF,   32'hB4FFFFE0};
        vecs[10] = '{4'd0,  5'd1,  5'd2,  5'd0,  26'h8,       32'hF8408041};
        vecs[11] = '{4'd4,  5'd0,  5'd0,  5'd0,  26'h0,       32'hCB000000};
        vecs[12] = '{4'd15, 5'd3,  5'd3,  5'd3,  26'h5,       32'h0};
        vecs[13] = '{4'd9,  5'd0,  5'd0,  5'd0,  26'h10,      32'h14000010};

        reset = 1'b1; start = 1'b0; base_addr = '0; num_instr = '0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rn = '0;
        bus.in_rm = '0; bus.in_imm = '0; bus.imem_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // single ADD, write one cycle after the handshake
        session(64'h100, 16'd1);
        send(4'd3, 5'd3, 5'd1, 5'd2, 26'd0, 32'h8B020023);
        @(negedge clk);
        chk("lat_we", 64'(bus.imem_we), 64'd1);
        chk("lat_addr", bus.imem_addr, 64'h100);
        chk("lat_data", {32'd0, bus.imem_wdata}, 64'h8B020023);
        wait_done("single", 20, 16'd1, 1'b0);

        // three-instruction program with an ignored start mid-session
        session(64'h1000, 16'd3);
        send(4'd0, 5'd1, 5'd2, 5'd0, 26'd8, 32'hF8408041);
        start = 1'b1; base_addr = 64'hDEAD_0000; num_instr = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        send(4'd2, 5'd5, 5'd0, 5'd0, 26'd3, 32'hB4000065);
        send(4'd9, 5'd0, 5'd0, 5'd0, 26'h10, 32'h14000010);
        wait_done("prog3", 20, 16'd3, 1'b0);

        // memory backpressure on the first of two writes
        session(64'h400, 16'd2);
        bus.imem_busy = 1'b1;
        send(4'd3, 5'd3, 5'd1, 5'd2, 26'd0, 32'h8B020023);
        bus.in_valid = 1'b1; bus.in_op = 4'd6; bus.in_rd = 5'd31; bus.in_rn = 5'd30; bus.in_rm = 5'd29;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_we", 64'(bus.imem_we), 64'd1);
            chk("stall_addr", bus.imem_addr, 64'h400);
            chk("stall_data", {32'd0, bus.imem_wdata}, 64'h8B020023);
            chk("stall_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.imem_busy = 1'b0;
        send(4'd6, 5'd31, 5'd30, 5'd29, 26'd0, 32'hAA1D03DF);
        wait_done("stall", 20, 16'd2, 1'b0);

        // invalid op is consumed without a write
        session(64'h500, 16'd2);
        send(4'd12, 5'd1, 5'd1, 5'd1, 26'd0, 32'h0);
        send(4'd4, 5'd0, 5'd0, 5'd0, 26'd0, 32'hCB000000);
        wait_done("invalid", 20, 16'd1, 1'b1);

        // empty session
        session(64'h200, 16'd0);
        wait_done("empty", 2, 16'd0, 1'b0);

        // table session: every op, random backpressure, address wrap past 2^64
        session(64'hFFFF_FFFF_FFFF_FFE0, 16'd14);
        rand_busy = 1'b1;
        for (int i = 0; i < 14; i++)
            send(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, vecs[i].word);
        wait_done("table", 300, 16'd12, 1'b1);
        rand_busy = 1'b0;
        @(posedge clk); #1;
        bus.imem_busy = 1'b0;

        // reset mid-session aborts the pending write
        session(64'h300, 16'd4);
        bus.imem_busy = 1'b1;
        send(4'd3, 5'd3, 5'd1, 5'd2, 26'd0, 32'h8B020023);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("abort");
        exp_q.delete();
        wr_seen = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.imem_busy = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = 4'd3;
        repeat (10) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("abort_no_write", 64'(wr_seen), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
